game_ctrl: RTL and testbench

- Top-level game sequencer for the breakout datapath.
- Owns the game flow: idle → serve → play → life lost / win / game over.
- Gates the ball datapath's advance rate with a tick enable and issues its resets. Tracks lives, score and a brick-hit mask from the ball block's erase events.
- Sits between the user buttons and the ball/paddle datapath; its outputs also feed the VGA overlay and sound.

---
 rtl/game_ctrl.sv | 179 +++++++++++++++++
 tb/tb_game_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// game_ctrl -- top-level sequencer for the breakout datapath.
//
// Runs the game flow IDLE -> SERVE -> PLAY -> LOST / WIN / OVER. It paces
// the ball datapath with a one-cycle tick enable and holds that datapath in
// reset whenever the ball must not move. It also tracks lives, score and
// which bricks have been hit.
//
// Optional build macro: GAME_CTRL_PAUSE_EN adds a pause_btn input and a
// PAUSE state (encoding 6). The default build has neither.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   start_btn    in   synchronised start button (level)
//   pause_btn    in   synchronised pause button (level, GAME_CTRL_PAUSE_EN only)
//   ball_y       in   current ball y from the ball datapath
//   erase_enable in   brick-hit pulse from the ball datapath
//   e_pos        in   index of the brick hit, valid with erase_enable
//   ball_tick    out  one-cycle advance enable for the ball datapath
//   ball_rst     out  hold ball position/velocity in reset (level)
//   field_rst    out  one-cycle pulse that restores all bricks
//   state        out  FSM state: 0 IDLE 1 SERVE 2 PLAY 3 LOST 4 WIN 5 OVER (6 PAUSE)
//   lives        out  remaining lives
//   score        out  bricks destroyed this game (saturates at 63)
//   hit_mask     out  bit i set once brick i has been hit
//   win          out  high while in WIN
//   game_over    out  high while in OVER
//
// ball_tick is an enable, not a handshake: the ball datapath advances in
// exactly the cycles where it is high and never pushes back.
//
// All outputs are registers. The outputs that depend on the state are loaded
// from the next-state value, so they change on the same edge as state.
module game_ctrl #(
  parameter int LIVES       = 3,
  parameter int BLOCKS      = 12,
  parameter int TICK_DIV    = 833333,
  parameter int SERVE_TICKS = 60,
  parameter int LOST_Y      = 473
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_btn,
`ifdef GAME_CTRL_PAUSE_EN
  input  logic              pause_btn,
`endif
  input  logic [9:0]        ball_y,
  input  logic              erase_enable,
  input  logic [5:0]        e_pos,
  output logic              ball_tick,
  output logic              ball_rst,
  output logic              field_rst,
  output logic [2:0]        state,
  output logic [2:0]        lives,
  output logic [5:0]        score,
  output logic [BLOCKS-1:0] hit_mask,
  output logic              win,
  output logic              game_over
);

  localparam int DW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SERVE_TICKS + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    LOST  = 3'd3,
    WIN   = 3'd4,
    OVER  = 3'd5
`ifdef GAME_CTRL_PAUSE_EN
    ,PAUSE = 3'd6
`endif
  } st_e;

  st_e               cur, nxt;
  logic [DW-1:0]     div_cnt;
  logic [SW-1:0]     serve_cnt;
  logic              start_q;
  logic              wrap, start_edge, hit_ok, all_hit, lost_now, serve_done;
  logic [BLOCKS-1:0] mask_sel, mask_new;
`ifdef GAME_CTRL_PAUSE_EN
  logic              pause_q, pause_edge;
`endif

  assign state = cur;

  always_comb begin
    wrap       = (div_cnt == DW'(TICK_DIV - 1));
    start_edge = start_btn & ~start_q;
`ifdef GAME_CTRL_PAUSE_EN
    pause_edge = pause_btn & ~pause_q;
`endif
    // One-hot select of the hit brick; an index past the last brick shifts
    // the bit out entirely, so out-of-range hits select nothing.
    mask_sel   = BLOCKS'(1) << e_pos;
    hit_ok     = (cur == PLAY) && erase_enable && (mask_sel != '0) &&
                 ((hit_mask & mask_sel) == '0);
    mask_new   = hit_ok ? (hit_mask | mask_sel) : hit_mask;
    all_hit    = &mask_new;
    lost_now   = (ball_y >= 10'(LOST_Y));
    serve_done = wrap && (serve_cnt == SW'(SERVE_TICKS - 1));

    nxt = cur;
    case (cur)
      IDLE, WIN, OVER: if (start_edge) nxt = SERVE;
      SERVE:           if (serve_done) nxt = PLAY;
      PLAY: begin
        // Clearing the last brick wins even if the ball is lost in the same cycle.
        if (all_hit)       nxt = WIN;
        else if (lost_now) nxt = LOST;
`ifdef GAME_CTRL_PAUSE_EN
        else if (pause_edge) nxt = PAUSE;
`endif
      end
      LOST:            nxt = (lives <= 3'd1) ? OVER : SERVE;
`ifdef GAME_CTRL_PAUSE_EN
      PAUSE:           if (pause_edge) nxt = PLAY;
`endif
      default:         nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // The edge detectors track the buttons even during reset, so a button
    // held through reset release does not count as a fresh press.
    start_q <= start_btn;
`ifdef GAME_CTRL_PAUSE_EN
    pause_q <= pause_btn;
`endif
    if (reset) begin
      cur       <= IDLE;
      div_cnt   <= '0;
      serve_cnt <= '0;
      lives     <= '0;
      score     <= '0;
      hit_mask  <= '0;
      ball_tick <= 1'b0;
      ball_rst  <= 1'b1;
      field_rst <= 1'b0;
      win       <= 1'b0;
      game_over <= 1'b0;
    end else begin
      cur       <= nxt;
      div_cnt   <= wrap ? '0 : div_cnt + DW'(1);
      field_rst <= 1'b0;
      case (cur)
        IDLE, WIN, OVER: begin
          if (start_edge) begin
            lives     <= 3'(LIVES);
            score     <= '0;
            hit_mask  <= '0;
            field_rst <= 1'b1;
            serve_cnt <= '0;
          end
        end
        SERVE: if (wrap) serve_cnt <= serve_cnt + SW'(1);
        PLAY: begin
          if (hit_ok) begin
            hit_mask <= mask_new;
            score    <= (score == 6'd63) ? score : score + 6'd1;
          end
        end
        LOST: begin
          if (lives != 3'd0) lives <= lives - 3'd1;
          serve_cnt <= '0;
        end
        default: ;
      endcase
      // The divider reaches TICK_DIV-1 on the next cycle exactly when it
      // holds TICK_DIV-2 now, which lines the registered tick up with it.
      ball_tick <= (nxt == PLAY) && (div_cnt == DW'(TICK_DIV - 2));
      ball_rst  <= (nxt == IDLE) || (nxt == SERVE) || (nxt == LOST) || (nxt == OVER);
      win       <= (nxt == WIN);
      game_over <= (nxt == OVER);
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl -- self-checking bench for game_ctrl.
//
// A small reference model of the game rules predicts every output word for
// each clock edge; the prediction is queued when the inputs are driven and
// popped and compared once the DUT has clocked. Directed scenarios follow
// the game flow, then a randomised phase mixes starts, hits, losses and resets.
module tb_game_ctrl;

  localparam int LIVES       = 2;
  localparam int BLOCKS      = 4;
  localparam int TICK_DIV    = 4;
  localparam int SERVE_TICKS = 2;
  localparam int LOST_Y      = 473;
  localparam int W           = 21;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        start_btn = 1'b0;
  logic [9:0]  ball_y = '0;
  logic        erase_enable = 1'b0;
  logic [5:0]  e_pos = '0;
`ifdef GAME_CTRL_PAUSE_EN
  logic        pause_btn = 1'b0;
`endif
  logic        ball_tick, ball_rst, field_rst, win, game_over;
  logic [2:0]  state, lives;
  logic [5:0]  score;
  logic [BLOCKS-1:0] hit_mask;

  game_ctrl #(
    .LIVES(LIVES), .BLOCKS(BLOCKS), .TICK_DIV(TICK_DIV),
    .SERVE_TICKS(SERVE_TICKS), .LOST_Y(LOST_Y)
  ) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn),
`ifdef GAME_CTRL_PAUSE_EN
    .pause_btn(pause_btn),
`endif
    .ball_y(ball_y), .erase_enable(erase_enable), .e_pos(e_pos),
    .ball_tick(ball_tick), .ball_rst(ball_rst), .field_rst(field_rst),
    .state(state), .lives(lives), .score(score), .hit_mask(hit_mask),
    .win(win), .game_over(game_over)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // reference model state
  int         m_st = 0, m_lives = 0, m_score = 0, m_scnt = 0, m_div = 0;
  logic [3:0] m_mask = '0;
  logic       m_start_q = 1'b0;

  function automatic logic [W-1:0] dut_word();
    return {state, lives, score, hit_mask, ball_rst, field_rst, ball_tick, win, game_over};
  endfunction

  // Predict the outputs after the coming edge, queue them, clock, compare.
  task automatic step(input string tag);
    int st, lv, sc, sn, dv, idx;
    logic [3:0] mk;
    logic frst, wrap, se, brst, tk, wn, ov;
    st = m_st; lv = m_lives; sc = m_score; sn = m_scnt; dv = m_div; mk = m_mask;
    frst = 1'b0;
    se = start_btn && !m_start_q;
    if (reset) begin
      st = 0; lv = 0; sc = 0; mk = '0; sn = 0; dv = 0;
    end else begin
      wrap = (m_div == TICK_DIV - 1);
      dv = wrap ? 0 : m_div + 1;
      case (m_st)
        0, 4, 5: if (se) begin
          lv = LIVES; sc = 0; mk = '0; frst = 1'b1; sn = 0; st = 1;
        end
        1: if (wrap) begin
          sn = m_scnt + 1;
          if (sn == SERVE_TICKS) st = 2;
        end
        2: begin
          idx = int'(e_pos);
          if (erase_enable && idx < BLOCKS) begin
            if (!m_mask[idx]) begin
              mk[idx] = 1'b1;
              sc = (m_score < 63) ? m_score + 1 : 63;
            end
          end
          if (mk == 4'hF) st = 4;
          else if (int'(ball_y) >= LOST_Y) st = 3;
        end
        3: begin
          lv = (m_lives > 0) ? m_lives - 1 : 0;
          if (m_lives <= 1) st = 5;
          else begin sn = 0; st = 1; end
        end
        default: st = m_st;
      endcase
    end
    m_start_q = start_btn;
    m_st = st; m_lives = lv; m_score = sc; m_scnt = sn; m_div = dv; m_mask = mk;
    brst = (st == 0) || (st == 1) || (st == 3) || (st == 5);
    tk   = (st == 2) && (dv == TICK_DIV - 1);
    wn   = (st == 4);
    ov   = (st == 5);
    exp_q.push_back({3'(st), 3'(lv), 6'(sc), mk, brst, frst, tk, wn, ov});
    @(posedge clk);
    #1;
    check_eq(tag, 32'(dut_word()), 32'(exp_q.pop_front()));
  endtask

  // driver tasks
  task automatic run_until(input int target, input int budget, input string tag, output int n);
    n = 0;
    while (int'(state) != target && n < budget) begin
      step(tag);
      n++;
    end
    check_eq({tag, "_reach"}, 32'(state), 32'(target));
  endtask

  task automatic hit(input int idx, input string tag);
    erase_enable = 1'b1;
    e_pos = 6'(idx);
    step(tag);
    erase_enable = 1'b0;
  endtask

  task automatic pulse_start(input string tag);
    start_btn = 1'b1;
    step(tag);
    start_btn = 1'b0;
  endtask

  initial begin
    int n, ticks;

    // reset for three cycles
    for (int i = 0; i < 3; i++) step("reset");
    check_eq("rst_vals", 32'({state, lives, score, ball_rst, field_rst, ball_tick}),
             32'({3'd0, 3'd0, 6'd0, 1'b1, 1'b0, 1'b0}));
    reset = 1'b0;

    // start -> SERVE, field restore pulse, then PLAY after the serve hold
    pulse_start("start");
    check_eq("start_frst", 32'(field_rst), 32'd1);
    check_eq("start_state", 32'({state, lives, ball_rst}), 32'({3'd1, 3'd2, 1'b1}));
    run_until(2, 40, "serve", n);
    check_eq("serve_len", 32'(n), 32'd7);
    ticks = 0;
    for (int i = 0; i < 8; i++) begin
      step("play_tick");
      if (ball_tick) ticks++;
    end
    check_eq("tick_count", 32'(ticks), 32'd2);

    // hits: new, repeat, out of range
    hit(2, "hit2");
    hit(2, "hit2_rep");
    hit(9, "hit9");
    check_eq("mask_0100", 32'(hit_mask), 32'h4);
    check_eq("score_1", 32'(score), 32'd1);

    // life lost, serve again, lose last life
    ball_y = 10'd473;
    step("lost");
    check_eq("lost_state", 32'(state), 32'd3);
    ball_y = 10'd0;
    step("lost_exit");
    check_eq("lost_exit", 32'({state, lives, hit_mask}), 32'({3'd1, 3'd1, 4'b0100}));
    run_until(2, 40, "reserve", n);
    ball_y = 10'd473;
    step("lost2");
    ball_y = 10'd0;
    step("over");
    check_eq("over_vals", 32'({state, lives, game_over}), 32'({3'd5, 3'd0, 1'b1}));

    // new game from OVER, clear every brick; last hit coincides with loss
    pulse_start("restart_over");
    run_until(2, 40, "serve3", n);
    hit(0, "win_h0");
    hit(1, "win_h1");
    hit(2, "win_h2");
    ball_y = 10'd480;
    hit(3, "win_h3");
    ball_y = 10'd0;
    check_eq("win_vals", 32'({state, win, hit_mask}), 32'({3'd4, 1'b1, 4'hF}));
    ticks = 0;
    for (int i = 0; i < 8; i++) begin
      erase_enable = (i == 3);
      step("win_hold");
      if (ball_tick) ticks++;
    end
    erase_enable = 1'b0;
    check_eq("win_no_tick", 32'(ticks), 32'd0);

    // new game from WIN, score 3, then reset mid-play with start held
    pulse_start("restart_win");
    check_eq("win_restart_frst", 32'({field_rst, hit_mask, score}), 32'({1'b1, 4'h0, 6'd0}));
    run_until(2, 40, "serve4", n);
    hit(0, "s3_h0");
    hit(1, "s3_h1");
    hit(2, "s3_h2");
    check_eq("score_3", 32'(score), 32'd3);
    reset = 1'b1;
    start_btn = 1'b1;
    step("rst_mid");
    check_eq("rst_mid", 32'({state, score, lives, ball_rst}), 32'({3'd0, 6'd0, 3'd0, 1'b1}));
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step("held_start");
    check_eq("held_start", 32'(state), 32'd0);
    start_btn = 1'b0;
    step("release");
    pulse_start("repress");
    check_eq("repress", 32'(state), 32'd1);

    // randomised play
    for (int i = 0; i < 600; i++) begin
      reset        = ($urandom_range(0, 199) == 0);
      start_btn    = ($urandom_range(0, 24) == 0);
      erase_enable = ($urandom_range(0, 3) == 0);
      e_pos        = 6'($urandom_range(0, 5));
      ball_y       = ($urandom_range(0, 29) == 0) ? 10'($urandom_range(473, 600))
                                                  : 10'($urandom_range(0, 472));
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
